// File: rtl/dpcr_datacall_tx.sv
// ReCOP-side DPCR datacall transmitter: FIFO of 31-bit payloads presented one at a time to the NOC
// with a toggle handshake on dpcr_out[31]. Define DPCR_TX_TIMEOUT_EN to enable the WAIT_ACK abort timer.
//
// state       | meaning
// RESYNC      | align request toggle to the Nios ack so the link is quiescent
// IDLE        | wait for a queued word and a quiescent link, then issue it
// LOAD        | word stable on dpcr_out for one cycle while the PIO captures it
// WAIT_ACK    | wait for the Nios to echo the request toggle
module dpcr_datacall_tx #(
    parameter int DEPTH       = 4,
    parameter int ACK_BIT     = 9,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic                     wr_en,
    input  logic [30:0]              wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              dpcr_out,
    input  logic [9:0]               sig_in,
    output logic                     busy,
    output logic                     sent_pulse,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_RESYNC   = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_LOAD     = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          ack_q, ack_d;
    logic [31:0]   dpcr_q, dpcr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [30:0]   mem_q [DEPTH];
    logic [30:0]   mem_d [DEPTH];
    logic          sent_q, sent_d;
    logic          ovf_q, ovf_d;

    logic full_c;
    logic push;
    logic pop;
    logic ack_match;
    logic sig_unused;

    assign sig_unused = ^sig_in;

`ifdef DPCR_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          terr_q, terr_d;
`else
    localparam int TMO_UNUSED = TIMEOUT_CYC;
`endif

    // full is taken from the registered count, so a push at full is refused even if a pop happens this cycle
    always_comb begin
        full_c    = (count_q == FULL_CNT);
        push      = wr_en && !full_c;
        ack_match = (ack_q == dpcr_q[31]);
        pop       = (state_q == ST_IDLE) && (count_q != '0) && ack_match;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ack_d   = sig_in[ACK_BIT];
        state_d = state_q;
        dpcr_d  = dpcr_q;
        sent_d  = 1'b0;
        ovf_d   = ovf_q | (wr_en & full_c);
`ifdef DPCR_TX_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        terr_d    = terr_q;
`endif
        case (state_q)
            ST_RESYNC: begin
                // Copy the ack value being registered this edge so toggle == ack_r right afterwards.
                dpcr_d[31] = ack_d;
                state_d    = ST_IDLE;
            end
            ST_IDLE: begin
                if (pop) begin
                    dpcr_d  = {~dpcr_q[31], mem_q[rd_ptr_q]};
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT_ACK;
`ifdef DPCR_TX_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_WAIT_ACK: begin
                if (ack_match) begin
                    sent_d  = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef DPCR_TX_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_RESYNC;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_RESYNC;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q  <= ST_RESYNC;
            ack_q    <= 1'b0;
            dpcr_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sent_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dpcr_q   <= dpcr_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sent_q   <= sent_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are valid.
    always_ff @(posedge clk_clk) begin
        mem_q <= mem_d;
    end

`ifdef DPCR_TX_TIMEOUT_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tmo_cnt_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            terr_q    <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign full       = full_c;
    assign count      = count_q;
    assign dpcr_out   = dpcr_q;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_WAIT_ACK);
    assign sent_pulse = sent_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_dpcr_datacall_tx.sv
// Bench for dpcr_datacall_tx: queue-based transfer model checked every cycle, directed scenarios, random traffic.
module tb_dpcr_datacall_tx;

    localparam int DEPTH = 4;
    localparam int TC    = 16;
`ifdef DPCR_TX_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk_clk;
    logic        reset_reset;
    logic        wr_en;
    logic [30:0] wr_data;
    logic        full;
    logic [2:0]  count;
    logic [31:0] dpcr_out;
    logic [9:0]  sig_in;
    logic        busy;
    logic        sent_pulse;
    logic        overflow;
    logic        timeout_err;

    dpcr_datacall_tx #(.DEPTH(DEPTH), .ACK_BIT(9), .TIMEOUT_CYC(TC)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .count       (count),
        .dpcr_out    (dpcr_out),
        .sig_in      (sig_in),
        .busy        (busy),
        .sent_pulse  (sent_pulse),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Transfer model: a word is queued, then in flight (issue, one capture cycle, then waiting), then retired.
    logic [30:0] mq[$];
    logic [31:0] m_dpcr;
    logic        m_ack, m_prev_ack, m_full;
    logic        m_resync, m_flight, m_loaded, m_sent, m_ovf, m_terr;
    int          m_wcnt;
    logic        model_valid = 1'b0;

    always @(posedge clk_clk) begin
        if (reset_reset) begin
            mq.delete();
            m_dpcr = '0; m_ack = 1'b0; m_resync = 1'b1; m_flight = 1'b0; m_loaded = 1'b0;
            m_sent = 1'b0; m_ovf = 1'b0; m_terr = 1'b0; m_wcnt = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_full     = (mq.size() == DEPTH);
            m_prev_ack = m_ack;
            m_ack      = sig_in[9];
            m_sent     = 1'b0;
            if (m_resync) begin
                m_dpcr[31] = m_ack;
                m_resync   = 1'b0;
            end else if (!m_flight) begin
                if (mq.size() > 0 && m_prev_ack == m_dpcr[31]) begin
                    m_dpcr   = {~m_dpcr[31], mq.pop_front()};
                    m_flight = 1'b1;
                    m_loaded = 1'b0;
                end
            end else if (!m_loaded) begin
                m_loaded = 1'b1;
                m_wcnt   = 0;
            end else if (m_prev_ack == m_dpcr[31]) begin
                m_sent   = 1'b1;
                m_flight = 1'b0;
            end else if (TMO && m_wcnt == TC - 1) begin
                m_terr   = 1'b1;
                m_flight = 1'b0;
                m_resync = 1'b1;
            end else begin
                m_wcnt++;
            end
            if (wr_en) begin
                if (m_full) m_ovf = 1'b1;
                else mq.push_back(wr_data);
            end
        end
    end

    always @(negedge clk_clk) begin
        if (model_valid) begin
            chk("m_count",    32'(count),       32'(mq.size()));
            chk("m_full",     32'(full),        32'(mq.size() == DEPTH));
            chk("m_dpcr",     dpcr_out,         m_dpcr);
            chk("m_busy",     32'(busy),        32'(m_flight));
            chk("m_sent",     32'(sent_pulse),  32'(m_sent));
            chk("m_overflow", 32'(overflow),    32'(m_ovf));
            chk("m_timeout",  32'(timeout_err), 32'(m_terr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic do_reset(input logic ack);
        sig_in      = {ack, 9'($urandom)};
        wr_en       = 1'b0;
        reset_reset = 1'b1;
        tick(2);
        reset_reset = 1'b0;
        tick(1);
    endtask

    task automatic push(input logic [30:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    // Echo the current toggle and wait (bounded) for the next word to be issued.
    task automatic ack_and_next(input string nm, input logic [30:0] exp_pl, input logic exp_tog);
        int n;
        sig_in[9] = dpcr_out[31];
        n = 0;
        while (dpcr_out[31] == sig_in[9] && n < 40) begin
            tick(1);
            n++;
        end
        chk({nm, "_issued"}, 32'(dpcr_out[31] != sig_in[9]), 32'd1);
        chk({nm, "_word"}, dpcr_out, {exp_tog, exp_pl});
    endtask

    task automatic ack_and_drain(input string nm);
        int n;
        sig_in[9] = dpcr_out[31];
        n = 0;
        while (busy && n < 40) begin
            tick(1);
            n++;
        end
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;
        int n;
        int dly;
        reset_reset = 1'b1;
        wr_en       = 1'b0;
        wr_data     = '0;
        sig_in      = '0;

        // Reset with ack high: RESYNC aligns toggle to 1, first word goes out with toggle 0.
        do_reset(1'b1);
        chk("t1_resync", dpcr_out, 32'h8000_0000);
        chk("t1_busy0", 32'(busy), 32'd0);
        push(31'h1234);
        tick(1);
        chk("t1_word", dpcr_out, 32'h0000_1234);
        chk("t1_busy1", 32'(busy), 32'd1);
        ack_and_drain("t1");

        // Single word, echoed five cycles after it appears.
        do_reset(1'b0);
        push(31'h0000_00AB);
        tick(1);
        chk("t2_word", dpcr_out, 32'h8000_00AB);
        tick(4);
        chk("t2_hold", dpcr_out, 32'h8000_00AB);
        sig_in[9] = 1'b1;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (sent_pulse) npulse++;
        end
        chk("t2_npulse", 32'(npulse), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_hold_after", dpcr_out, 32'h8000_00AB);

        // Six back-to-back pushes: one in flight, four queued, sixth overflows.
        do_reset(1'b0);
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 31'h100 + 31'(i);
            tick(1);
        end
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_ovf0", 32'(overflow), 32'd0);
        wr_data = 31'h105;
        tick(1);
        wr_en = 1'b0;
        chk("t3_ovf1", 32'(overflow), 32'd1);
        chk("t3_first", dpcr_out, 32'h8000_0100);
        for (int k = 1; k < 5; k++) begin
            ack_and_next("t3_seq", 31'h100 + 31'(k), (k % 2) == 0);
        end
        ack_and_drain("t3");
        chk("t3_empty", 32'(count), 32'd0);

        // Reset during WAIT_ACK with three words queued.
        do_reset(1'b0);
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 31'h200 + 31'(i);
            tick(1);
        end
        wr_en = 1'b0;
        tick(1);
        chk("t4_count3", 32'(count), 32'd3);
        chk("t4_busy", 32'(busy), 32'd1);
        sig_in[9]   = 1'b1;
        reset_reset = 1'b1;
        tick(1);
        reset_reset = 1'b0;
        tick(1);
        chk("t4_count0", 32'(count), 32'd0);
        chk("t4_busy0", 32'(busy), 32'd0);
        chk("t4_resync", dpcr_out, 32'h8000_0000);
        tick(5);

        // WAIT_ACK with no echo: abort when the timer is built in, otherwise wait indefinitely.
        do_reset(1'b0);
        push(31'h300);
        push(31'h301);
        tick(30);
`ifdef DPCR_TX_TIMEOUT_EN
        chk("t5_terr", 32'(timeout_err), 32'd1);
        chk("t5_next", dpcr_out, 32'h8000_0301);
`else
        chk("t5_terr", 32'(timeout_err), 32'd0);
        chk("t5_stuck", dpcr_out, 32'h8000_0300);
`endif
        chk("t5_busy", 32'(busy), 32'd1);

        // Push coincident with a pop at count == 2.
        do_reset(1'b0);
        push(31'h400);
        push(31'h401);
        push(31'h402);
        chk("t6_count2", 32'(count), 32'd2);
        sig_in[9] = 1'b1;
        n = 0;
        while (!sent_pulse && n < 20) begin
            tick(1);
            n++;
        end
        chk("t6_sent", 32'(sent_pulse), 32'd1);
        push(31'h403);
        chk("t6_count_same", 32'(count), 32'd2);
        chk("t6_word1", dpcr_out, 32'h0000_0401);
        ack_and_next("t6_w2", 31'h402, 1'b1);
        ack_and_next("t6_w3", 31'h403, 1'b0);
        ack_and_drain("t6");

        // Random traffic with an emulated Nios echoing after random delays.
        do_reset(1'($urandom));
        dly = 0;
        for (int c = 0; c < 3000; c++) begin
            wr_en       = ($urandom % 100) < 35;
            wr_data     = 31'($urandom);
            sig_in[8:0] = 9'($urandom);
            reset_reset = ($urandom % 500) == 0;
            if (dpcr_out[31] != sig_in[9]) begin
                if (dly == 0) sig_in[9] = ~sig_in[9];
                else dly--;
            end else begin
                dly = $urandom_range(0, 6);
            end
            tick(1);
        end
        wr_en       = 1'b0;
        reset_reset = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
